sbox_seq_ctrl: RTL and testbench

Sequencer for the pipelined 2-share masked GF(2^8) inverter (GF256_INV, 3-cycle latency, 30 fresh random bits per cycle). It accepts a full masked state, issues one byte pair per cycle to the inverter, and tracks in-flight bytes with a valid/index pipeline. It writes the shared results back into a result register and gates the PRNG so randomness is drawn only while the inverter holds live data. It sits between the round controller and the single shared inverter instance.

---
 rtl/sbox_seq_ctrl_if.sv | 43 ++++
 rtl/sbox_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_sbox_seq_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sbox_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sbox_seq_ctrl_if
// Purpose  : Bundles the sequencer's round-controller, inverter and PRNG
//            signals. The slave modport is the sequencer's view.
//            The master modport is the surrounding environment's view.
// Revision : 1.0  initial release
// ============================================================================
interface sbox_seq_ctrl_if #(
    parameter int NBYTES = 16,
    parameter int RW     = 30
);
    // Round-controller side
    logic                  start;
    logic [8*NBYTES-1:0]   state_in0;
    logic [8*NBYTES-1:0]   state_in1;
    logic                  busy;
    logic                  done;
    logic [8*NBYTES-1:0]   state_out0;
    logic [8*NBYTES-1:0]   state_out1;
    // Shared masked inverter side
    logic [7:0]            inv_in0;
    logic [7:0]            inv_in1;
    logic [7:0]            inv_out0;
    logic [7:0]            inv_out1;
    logic [RW-1:0]         inv_ran;
    // PRNG side
    logic [RW-1:0]         prng_rnd;
    logic                  prng_en;

    modport slave (
        input  start, state_in0, state_in1, inv_out0, inv_out1, prng_rnd,
        output busy, done, state_out0, state_out1, inv_in0, inv_in1,
               inv_ran, prng_en
    );

    modport master (
        output start, state_in0, state_in1, inv_out0, inv_out1, prng_rnd,
        input  busy, done, state_out0, state_out1, inv_in0, inv_in1,
               inv_ran, prng_en
    );
endinterface
`default_nettype wire

// File: rtl/sbox_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sbox_seq_ctrl
// Purpose  : Feeds a masked state one byte pair per cycle into a single
//            pipelined 2-share GF(2^8) inverter. It tracks in-flight bytes
//            with a valid/index pipe and writes results back per share.
//            The PRNG is stepped only while the inverter can hold live data.
// Revision : 1.0  initial release
// ============================================================================
module sbox_seq_ctrl #(
    parameter int NBYTES = 16,
    parameter int LAT    = 3,
    parameter int RW     = 30
) (
    input  wire logic        clk,
    input  wire logic        rst,
    sbox_seq_ctrl_if.slave   bus
);

    localparam int             IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         cnt_q, cnt_d;
    logic [8*NBYTES-1:0]   in0_q, in1_q;
    logic [8*NBYTES-1:0]   out0_q, out1_q;
    logic [LAT-1:0]        vld_q;
    logic [IW-1:0]         idx_q [LAT];

    logic                  issuing;
    logic                  running;
    logic                  accept;
    logic                  cap_vld;
    logic [IW-1:0]         cap_idx;
    logic                  cap_last;

    assign issuing  = (state_q == S_ISSUE);
    assign running  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign accept   = (state_q == S_IDLE) && bus.start;
    assign cap_vld  = vld_q[LAT-1];
    assign cap_idx  = idx_q[LAT-1];
    assign cap_last = cap_vld && (cap_idx == LAST_IDX);

    // State and issue-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter stops at the last byte instead of wrapping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                end
            end
            S_ISSUE: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cap_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Input latch so the caller may change state_in once the run is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            in0_q <= '0;
            in1_q <= '0;
        end else if (accept) begin
            in0_q <= bus.state_in0;
            in1_q <= bus.state_in1;
        end
    end

    // Valid/index pipe mirroring the inverter latency; cleared on reset so
    // results still emerging from an aborted run are never written back
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= issuing;
            idx_q[0] <= issuing ? cnt_q : '0;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    // Result write-back; the two shares are kept strictly separate
    always_ff @(posedge clk) begin
        if (rst) begin
            out0_q <= '0;
            out1_q <= '0;
        end else if (cap_vld) begin
            out0_q[cap_idx*8 +: 8] <= bus.inv_out0;
            out1_q[cap_idx*8 +: 8] <= bus.inv_out1;
        end
    end

    // Inverter inputs are forced to zero outside issue to avoid stale shares
    always_comb begin
        bus.inv_in0 = 8'h00;
        bus.inv_in1 = 8'h00;
        if (issuing) begin
            bus.inv_in0 = in0_q[cnt_q*8 +: 8];
            bus.inv_in1 = in1_q[cnt_q*8 +: 8];
        end
    end

    // Randomness is drawn only while any inverter stage may hold live data
    always_comb begin
        bus.prng_en = running;
        bus.inv_ran = running ? bus.prng_rnd : '0;
    end

    assign bus.busy       = running;
    assign bus.done       = (state_q == S_DONE);
    assign bus.state_out0 = out0_q;
    assign bus.state_out1 = out1_q;

endmodule
`default_nettype wire

// File: tb/tb_sbox_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_seq_ctrl
// Purpose  : Randomized scoreboard bench for sbox_seq_ctrl with a behavioural
//            masked GF(2^8) inverter (AES field, LAT-cycle pipeline).
// Revision : 1.0  initial release
// ============================================================================
module tb_sbox_seq_ctrl;

    localparam int NB     = 16;
    localparam int LAT    = 3;
    localparam int RW     = 30;
    localparam int RUNLEN = NB + LAT + 1;   // start-to-done distance
    localparam int NEVER  = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sbox_seq_ctrl_if #(.NBYTES(NB), .RW(RW)) bus ();

    sbox_seq_ctrl #(.NBYTES(NB), .LAT(LAT), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural masked inverter ----------------
    logic [7:0] inv_tab [256];
    logic [7:0] p0 [LAT];
    logic [7:0] p1 [LAT];

    assign bus.inv_out0 = p0[LAT-1];
    assign bus.inv_out1 = p1[LAT-1];

    always @(posedge clk) begin
        logic [7:0] m, y;
        m = 8'($urandom);
        y = inv_tab[bus.inv_in0 ^ bus.inv_in1];
        p0[0] <= y ^ m;
        p1[0] <= m;
        for (int i = 1; i < LAT; i++) begin
            p0[i] <= p0[i-1];
            p1[i] <= p1[i-1];
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [8*NB-1:0] rnd_state();
        logic [8*NB-1:0] v;
        for (int i = 0; i < NB / 4; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int              dcyc;
        logic [8*NB-1:0] exp;
    } exp_t;

    exp_t            sb [$];
    int              run_s   = -1;
    int              run_end = NEVER;
    logic [8*NB-1:0] lat0, lat1;
    int              total = 0;
    int              bad   = 0;
    bit              chk_en  = 1'b0;
    bit              prev_rst = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // One cycle of stimulus; the reference model decides whether start is taken
    task automatic tick(input bit st, input bit rs,
                        input logic [8*NB-1:0] a0, input logic [8*NB-1:0] a1);
        int c;
        exp_t e;
        @(negedge clk);
        c = cyc;
        rst            = rs;
        bus.start      = st;
        bus.state_in0  = st ? a0 : rnd_state();
        bus.state_in1  = st ? a1 : rnd_state();
        bus.prng_rnd   = RW'($urandom);
        if (rs) begin
            if (run_s >= 0 && run_end > c) run_end = c;
            sb.delete();
        end else if (st && (run_s < 0 || c > run_end || c >= run_s + RUNLEN + 1)) begin
            run_s   = c;
            run_end = NEVER;
            lat0    = a0;
            lat1    = a1;
            e.dcyc  = c + RUNLEN;
            for (int i = 0; i < NB; i++) e.exp[8*i +: 8] = inv_tab[a0[8*i +: 8] ^ a1[8*i +: 8]];
            sb.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            int         x;
            bit         act_b;
            bit         busy_e;
            int         k;
            logic [7:0] e0, e1;
            exp_t       e;
            @(negedge clk);
            #1;
            if (chk_en) begin
                x      = cyc;
                act_b  = (run_s >= 0) && (x > run_s) && (x <= run_end);
                busy_e = act_b && (x <= run_s + RUNLEN - 1);
                e0 = 8'h00;
                e1 = 8'h00;
                if (act_b && x >= run_s + 1 && x <= run_s + NB) begin
                    k  = x - run_s - 1;
                    e0 = lat0[8*k +: 8];
                    e1 = lat1[8*k +: 8];
                end
                chk("busy",    bus.busy,    busy_e);
                chk("prng_en", bus.prng_en, busy_e);
                chk("inv_ran", bus.inv_ran, busy_e ? bus.prng_rnd : '0);
                chk("inv_in0", bus.inv_in0, e0);
                chk("inv_in1", bus.inv_in1, e1);
                if (prev_rst) begin
                    chk("rst_out0", bus.state_out0, '0);
                    chk("rst_out1", bus.state_out1, '0);
                end
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL done_unexpected cyc=%0d actual=1 expected=0", x);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cycle", x, e.dcyc);
                        chk("result", bus.state_out0 ^ bus.state_out1, e.exp);
                    end
                end else if (sb.size() > 0 && x >= sb[0].dcyc) begin
                    total++;
                    bad++;
                    $display("FAIL done_missing cyc=%0d actual=0 expected=1", x);
                    void'(sb.pop_front());
                end
            end
            prev_rst = rst;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [8*NB-1:0] s, m;
        inv_tab[0] = 8'h00;
        for (int a = 1; a < 256; a++) begin
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv_tab[a] = 8'(b);
            end
        end
        bus.start     = 1'b0;
        bus.state_in0 = '0;
        bus.state_in1 = '0;
        bus.prng_rnd  = '0;

        repeat (3) tick(0, 1, '0, '0);
        chk_en = 1'b1;
        repeat (10) tick(0, 0, '0, '0);

        // all-zero shares
        tick(1, 0, '0, '0);
        repeat (24) tick(0, 0, '0, '0);

        // byte order: byte i = i+1, random mask
        for (int i = 0; i < NB; i++) s[8*i +: 8] = 8'(i + 1);
        m = rnd_state();
        tick(1, 0, s ^ m, m);
        repeat (24) tick(0, 0, '0, '0);

        // starts during the run and in the done cycle are ignored;
        // the cycle after done accepts a new run
        s = rnd_state();
        m = rnd_state();
        tick(1, 0, s ^ m, m);
        for (int r = 1; r <= RUNLEN + 1; r++) begin
            tick((r == 5) || (r == RUNLEN) || (r == RUNLEN + 1), 0, rnd_state(), rnd_state());
        end
        repeat (24) tick(0, 0, '0, '0);

        // reset mid-run, then a clean run
        tick(1, 0, rnd_state(), rnd_state());
        repeat (9) tick(0, 0, '0, '0);
        tick(0, 1, '0, '0);
        repeat (5) tick(0, 0, '0, '0);
        tick(1, 0, rnd_state(), rnd_state());
        repeat (24) tick(0, 0, '0, '0);

        // back-to-back runs with different random states
        for (int n = 0; n < 4; n++) begin
            tick(1, 0, rnd_state(), rnd_state());
            repeat (RUNLEN) tick(0, 0, '0, '0);
        end
        repeat (25) tick(0, 0, '0, '0);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
